// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings
// and register-file constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  localparam int unsigned PIPE_REG_W = 5;
  localparam logic [PIPE_REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over
// the increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze controller for a 5-stage pipeline: load-use bubbles via a
// bubble-counter FSM, taken-branch squash, data-memory freeze, perf counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W      = PIPE_REG_W,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ifid_Rs_i,
  input  logic [REG_W-1:0] ifid_Rt_i,
  input  logic             ifid_UsesRt_i,
  input  logic             idex_MemRead_i,
  input  logic [REG_W-1:0] idex_Rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  input  logic             cnt_clr_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             if_flush_o,
  output logic             idex_flush_o,
  output logic             pipe_freeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e     state_q, state_d;
  state_e     saved_q, saved_d;
  state_e     eff_state;
  logic [2:0] bcnt_q, bcnt_d;
  logic       lu;
  logic       pc_write, ifid_stall, if_flush, idex_flush, pipe_freeze;
  logic       flush_evt;

  assign lu = idex_MemRead_i && (idex_Rt_i != REG_W'(ZERO_REG)) &&
              ((idex_Rt_i == ifid_Rs_i) ||
               (ifid_UsesRt_i && (idex_Rt_i == ifid_Rt_i)));

  // While frozen, behave as the state that was live when the freeze began.
  always_comb begin
    case (state_q)
      ST_STALL:  eff_state = ST_STALL;
      ST_FREEZE: eff_state = (saved_q == ST_STALL) ? ST_STALL : ST_RUN;
      default:   eff_state = ST_RUN;
    endcase
  end

  always_comb begin
    state_d     = eff_state;
    saved_d     = saved_q;
    bcnt_d      = bcnt_q;
    pc_write    = 1'b1;
    ifid_stall  = 1'b0;
    if_flush    = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    flush_evt   = 1'b0;
    if (dmem_busy_i) begin
      state_d     = ST_FREEZE;
      saved_d     = eff_state;
      pc_write    = 1'b0;
      ifid_stall  = 1'b1;
      pipe_freeze = 1'b1;
    end else if (branch_taken_i) begin
      state_d    = ST_RUN;
      bcnt_d     = 3'd0;
      if_flush   = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
    end else if (eff_state == ST_STALL) begin
      pc_write   = 1'b0;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      bcnt_d     = bcnt_q - 3'd1;
      if (bcnt_q <= 3'd1) begin
        state_d = ST_RUN;
        bcnt_d  = 3'd0;
      end
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      if (LU_BUBBLES > 1) begin
        state_d = ST_STALL;
        bcnt_d  = 3'(LU_BUBBLES - 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      bcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Reset forces every control low, including pc_write_o.
  assign pc_write_o    = rst_i & pc_write;
  assign ifid_stall_o  = rst_i & ifid_stall;
  assign if_flush_o    = rst_i & if_flush;
  assign idex_flush_o  = rst_i & idex_flush;
  assign pipe_freeze_o = rst_i & pipe_freeze;
  assign state_o       = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~pc_write_o),
    .clr_i (cnt_clr_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rst_i & flush_evt),
    .clr_i (cnt_clr_i),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: two instances share stimulus, one
// with a single bubble and narrow counters, one with three bubbles.
module tb_pipe_hazard_ctrl;

  logic       clk, rst_n;
  logic [4:0] rs, rt, ex_rt;
  logic       uses_rt, mr, br, busy, clr;

  logic        pw1, st1, iff1, idf1, fz1;
  logic [1:0]  state1;
  logic [2:0]  sc1, fc1;
  logic        pw3, st3, iff3, idf3, fz3;
  logic [1:0]  state3;
  logic [15:0] sc3, fc3;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_hazard_ctrl #(.REG_W(5), .LU_BUBBLES(1), .CNT_W(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .ifid_Rs_i(rs), .ifid_Rt_i(rt),
    .ifid_UsesRt_i(uses_rt), .idex_MemRead_i(mr), .idex_Rt_i(ex_rt),
    .branch_taken_i(br), .dmem_busy_i(busy), .cnt_clr_i(clr),
    .pc_write_o(pw1), .ifid_stall_o(st1), .if_flush_o(iff1),
    .idex_flush_o(idf1), .pipe_freeze_o(fz1), .state_o(state1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  pipe_hazard_ctrl #(.REG_W(5), .LU_BUBBLES(3), .CNT_W(16)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .ifid_Rs_i(rs), .ifid_Rt_i(rt),
    .ifid_UsesRt_i(uses_rt), .idex_MemRead_i(mr), .idex_Rt_i(ex_rt),
    .branch_taken_i(br), .dmem_busy_i(busy), .cnt_clr_i(clr),
    .pc_write_o(pw3), .ifid_stall_o(st3), .if_flush_o(iff3),
    .idex_flush_o(idf3), .pipe_freeze_o(fz3), .state_o(state3),
    .stall_cnt_o(sc3), .flush_cnt_o(fc3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mr = 1'b0; ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
    uses_rt = 1'b0; br = 1'b0; busy = 1'b0;
  endtask

  task automatic load_use_rs2();
    mr = 1'b1; ex_rt = 5'd2; rs = 5'd2;
  endtask

  task automatic clear_counters();
    tick(); idle(); clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    #3;
    n_cmp++; if (pw1 !== 1'b0) begin n_bad++; $display("FAIL rst_pw1 got=%0b want=0", pw1); end
    n_cmp++; if (pw3 !== 1'b0) begin n_bad++; $display("FAIL rst_pw3 got=%0b want=0", pw3); end
    n_cmp++; if (state3 !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d want=0", state3); end
    n_cmp++; if (sc3 !== 16'd0) begin n_bad++; $display("FAIL rst_sc got=%0d want=0", sc3); end
    n_cmp++; if (fc3 !== 16'd0) begin n_bad++; $display("FAIL rst_fc got=%0d want=0", fc3); end
    n_cmp++; if ({st3, iff3, idf3, fz3} !== 4'b0) begin n_bad++; $display("FAIL rst_ctl got=%b want=0000", {st3, iff3, idf3, fz3}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (pw3 !== 1'b1) begin n_bad++; $display("FAIL rst_rel_pw got=%0b want=1", pw3); end
  endtask

  task automatic test_load_use();
    clear_counters();
    tick(); load_use_rs2(); @(negedge clk);
    n_cmp++; if (pw1 !== 1'b0) begin n_bad++; $display("FAIL lu1_pw got=%0b want=0", pw1); end
    n_cmp++; if (st1 !== 1'b1) begin n_bad++; $display("FAIL lu1_stall got=%0b want=1", st1); end
    n_cmp++; if (idf1 !== 1'b1) begin n_bad++; $display("FAIL lu1_idf got=%0b want=1", idf1); end
    n_cmp++; if (pw3 !== 1'b0) begin n_bad++; $display("FAIL lu3_pw got=%0b want=0", pw3); end
    n_cmp++; if (state3 !== 2'd0) begin n_bad++; $display("FAIL lu3_st0 got=%0d want=0", state3); end
    tick(); idle(); @(negedge clk);
    n_cmp++; if (pw1 !== 1'b1) begin n_bad++; $display("FAIL lu1_done_pw got=%0b want=1", pw1); end
    n_cmp++; if (sc1 !== 3'd1) begin n_bad++; $display("FAIL lu1_sc got=%0d want=1", sc1); end
    n_cmp++; if (state3 !== 2'd1) begin n_bad++; $display("FAIL lu3_st1 got=%0d want=1", state3); end
    n_cmp++; if (pw3 !== 1'b0) begin n_bad++; $display("FAIL lu3_pw1 got=%0b want=0", pw3); end
    tick(); @(negedge clk);
    n_cmp++; if (state3 !== 2'd1) begin n_bad++; $display("FAIL lu3_st2 got=%0d want=1", state3); end
    n_cmp++; if (pw3 !== 1'b0) begin n_bad++; $display("FAIL lu3_pw2 got=%0b want=0", pw3); end
    tick(); @(negedge clk);
    n_cmp++; if (state3 !== 2'd0) begin n_bad++; $display("FAIL lu3_st3 got=%0d want=0", state3); end
    n_cmp++; if (pw3 !== 1'b1) begin n_bad++; $display("FAIL lu3_pw3 got=%0b want=1", pw3); end
    n_cmp++; if (sc3 !== 16'd3) begin n_bad++; $display("FAIL lu3_sc got=%0d want=3", sc3); end
  endtask

  task automatic test_no_stall();
    tick(); mr = 1'b1; ex_rt = 5'd0; rs = 5'd0; @(negedge clk);
    n_cmp++; if (pw3 !== 1'b1) begin n_bad++; $display("FAIL r0_pw got=%0b want=1", pw3); end
    n_cmp++; if (pw1 !== 1'b1) begin n_bad++; $display("FAIL r0_pw1 got=%0b want=1", pw1); end
    tick(); ex_rt = 5'd3; rs = 5'd1; rt = 5'd3; uses_rt = 1'b0; @(negedge clk);
    n_cmp++; if (pw3 !== 1'b1) begin n_bad++; $display("FAIL rt_unused_pw got=%0b want=1", pw3); end
    n_cmp++; if (st3 !== 1'b0) begin n_bad++; $display("FAIL rt_unused_stall got=%0b want=0", st3); end
    tick(); uses_rt = 1'b1; @(negedge clk);
    n_cmp++; if (pw3 !== 1'b0) begin n_bad++; $display("FAIL rt_used_pw got=%0b want=0", pw3); end
    n_cmp++; if (idf3 !== 1'b1) begin n_bad++; $display("FAIL rt_used_idf got=%0b want=1", idf3); end
    tick(); idle(); tick(); tick(); @(negedge clk);
    n_cmp++; if (state3 !== 2'd0) begin n_bad++; $display("FAIL rt_drain_st got=%0d want=0", state3); end
  endtask

  task automatic test_branch();
    clear_counters();
    tick(); load_use_rs2(); @(negedge clk);
    tick(); idle(); br = 1'b1; @(negedge clk);
    n_cmp++; if (state3 !== 2'd1) begin n_bad++; $display("FAIL br_in_stall got=%0d want=1", state3); end
    n_cmp++; if (iff3 !== 1'b1) begin n_bad++; $display("FAIL br_iff got=%0b want=1", iff3); end
    n_cmp++; if (idf3 !== 1'b1) begin n_bad++; $display("FAIL br_idf got=%0b want=1", idf3); end
    n_cmp++; if (pw3 !== 1'b1) begin n_bad++; $display("FAIL br_pw got=%0b want=1", pw3); end
    n_cmp++; if (st3 !== 1'b0) begin n_bad++; $display("FAIL br_stall got=%0b want=0", st3); end
    tick(); br = 1'b0; @(negedge clk);
    n_cmp++; if (state3 !== 2'd0) begin n_bad++; $display("FAIL br_next_st got=%0d want=0", state3); end
    n_cmp++; if (pw3 !== 1'b1) begin n_bad++; $display("FAIL br_next_pw got=%0b want=1", pw3); end
    n_cmp++; if (fc3 !== 16'd1) begin n_bad++; $display("FAIL br_fc3 got=%0d want=1", fc3); end
    n_cmp++; if (fc1 !== 3'd1) begin n_bad++; $display("FAIL br_fc1 got=%0d want=1", fc1); end
    tick(); load_use_rs2(); br = 1'b1; @(negedge clk);
    n_cmp++; if (pw1 !== 1'b1) begin n_bad++; $display("FAIL brlu_pw got=%0b want=1", pw1); end
    n_cmp++; if (st1 !== 1'b0) begin n_bad++; $display("FAIL brlu_stall got=%0b want=0", st1); end
    tick(); idle(); @(negedge clk);
    n_cmp++; if (state3 !== 2'd0) begin n_bad++; $display("FAIL brlu_st got=%0d want=0", state3); end
    n_cmp++; if (fc3 !== 16'd2) begin n_bad++; $display("FAIL brlu_fc got=%0d want=2", fc3); end
  endtask

  task automatic test_freeze();
    clear_counters();
    tick(); load_use_rs2(); @(negedge clk);
    tick(); idle(); busy = 1'b1; @(negedge clk);
    n_cmp++; if (state3 !== 2'd1) begin n_bad++; $display("FAIL fz_pre_st got=%0d want=1", state3); end
    n_cmp++; if ({fz3, st3, pw3, iff3, idf3} !== 5'b11000) begin n_bad++; $display("FAIL fz_ctl0 got=%b want=11000", {fz3, st3, pw3, iff3, idf3}); end
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      n_cmp++; if (state3 !== 2'd2) begin n_bad++; $display("FAIL fz_st c%0d got=%0d want=2", i, state3); end
      n_cmp++; if ({fz3, pw3} !== 2'b10) begin n_bad++; $display("FAIL fz_ctl c%0d got=%b want=10", i, {fz3, pw3}); end
    end
    tick(); busy = 1'b0; @(negedge clk);
    n_cmp++; if (state3 !== 2'd2) begin n_bad++; $display("FAIL fz_exit_st got=%0d want=2", state3); end
    n_cmp++; if ({fz3, pw3, idf3} !== 3'b001) begin n_bad++; $display("FAIL fz_exit_ctl got=%b want=001", {fz3, pw3, idf3}); end
    tick(); @(negedge clk);
    n_cmp++; if (state3 !== 2'd1) begin n_bad++; $display("FAIL fz_last_st got=%0d want=1", state3); end
    n_cmp++; if (pw3 !== 1'b0) begin n_bad++; $display("FAIL fz_last_pw got=%0b want=0", pw3); end
    tick(); @(negedge clk);
    n_cmp++; if (state3 !== 2'd0) begin n_bad++; $display("FAIL fz_done_st got=%0d want=0", state3); end
    n_cmp++; if (pw3 !== 1'b1) begin n_bad++; $display("FAIL fz_done_pw got=%0b want=1", pw3); end
    n_cmp++; if (sc3 !== 16'd7) begin n_bad++; $display("FAIL fz_sc3 got=%0d want=7", sc3); end
    n_cmp++; if (sc1 !== 3'd5) begin n_bad++; $display("FAIL fz_sc1 got=%0d want=5", sc1); end
  endtask

  task automatic test_saturate();
    clear_counters();
    for (int i = 0; i < 10; i++) begin
      tick(); busy = 1'b1; @(negedge clk);
    end
    tick(); busy = 1'b0; @(negedge clk);
    n_cmp++; if (sc1 !== 3'd7) begin n_bad++; $display("FAIL sat_sc1 got=%0d want=7", sc1); end
    n_cmp++; if (sc3 !== 16'd10) begin n_bad++; $display("FAIL sat_sc3 got=%0d want=10", sc3); end
    n_cmp++; if (pw1 !== 1'b1) begin n_bad++; $display("FAIL sat_pw got=%0b want=1", pw1); end
  endtask

  task automatic test_reset_mid_stall();
    tick(); load_use_rs2(); @(negedge clk);
    tick(); idle(); @(negedge clk);
    n_cmp++; if (state3 !== 2'd1) begin n_bad++; $display("FAIL rms_pre_st got=%0d want=1", state3); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (state3 !== 2'd0) begin n_bad++; $display("FAIL rms_st got=%0d want=0", state3); end
    n_cmp++; if (sc3 !== 16'd0) begin n_bad++; $display("FAIL rms_sc got=%0d want=0", sc3); end
    n_cmp++; if (fc3 !== 16'd0) begin n_bad++; $display("FAIL rms_fc got=%0d want=0", fc3); end
    n_cmp++; if ({pw3, st3, idf3} !== 3'b000) begin n_bad++; $display("FAIL rms_ctl got=%b want=000", {pw3, st3, idf3}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (pw3 !== 1'b1) begin n_bad++; $display("FAIL rms_rel_pw got=%0b want=1", pw3); end
  endtask

  task automatic test_clr_concurrent();
    tick(); busy = 1'b1; @(negedge clk);
    tick(); busy = 1'b0; load_use_rs2(); clr = 1'b1; @(negedge clk);
    n_cmp++; if (sc3 !== 16'd1) begin n_bad++; $display("FAIL clr_pre_sc got=%0d want=1", sc3); end
    n_cmp++; if (pw3 !== 1'b0) begin n_bad++; $display("FAIL clr_pw got=%0b want=0", pw3); end
    tick(); idle(); clr = 1'b0; @(negedge clk);
    n_cmp++; if (sc3 !== 16'd0) begin n_bad++; $display("FAIL clr_sc got=%0d want=0", sc3); end
    n_cmp++; if (state3 !== 2'd1) begin n_bad++; $display("FAIL clr_st got=%0d want=1", state3); end
    tick(); @(negedge clk);
    n_cmp++; if (sc3 !== 16'd1) begin n_bad++; $display("FAIL clr_post_sc got=%0d want=1", sc3); end
    tick(); @(negedge clk);
    n_cmp++; if (state3 !== 2'd0) begin n_bad++; $display("FAIL clr_end_st got=%0d want=0", state3); end
    n_cmp++; if (sc3 !== 16'd2) begin n_bad++; $display("FAIL clr_end_sc got=%0d want=2", sc3); end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_freeze();
    test_saturate();
    test_reset_mid_stall();
    test_clr_concurrent();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
